bcd_counter_chain: RTL and testbench
====================================

Name: bcd_counter_chain

Overview:
- Parametrised multi-digit cascaded counter for the stopwatch/timer datapath.
- Replaces per-digit counters clocked by derived sub-clocks. Runs on one system clock and advances on a single-cycle enable tick from the prescaler.
- Counts up or down, with per-digit modulus, synchronous clear and parallel load, and wrap and done flags.
- Its output feeds the 7-seg digit mux directly.

Parameters:
- N_DIGITS, 4, number of cascaded digits (1..8).
- DIGIT_W, 4, bits per digit.
- DIGIT_MAX, 16'h5959, packed per-digit maximum. Digit k's maximum is DIGIT_MAX[k*DIGIT_W +: DIGIT_W]; digit 0 is least significant. Width is N_DIGITS*DIGIT_W.
- DOWN_WRAP, 0, down-count behaviour at zero: 1 = wrap to all-max; 0 = saturate at zero and set done.

Ports:
- i_clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- i_tick  input  1  count enable pulse, one i_clk cycle wide.
- i_run  input  1  1 = counting allowed; 0 = hold.
- i_dir  input  1  0 = up, 1 = down.
- i_clear  input  1  synchronous clear to zero.
- i_load  input  1  synchronous parallel load.
- i_load_val  input  N_DIGITS*DIGIT_W  load value, same packing as DIGIT_MAX.
- o_count  output  N_DIGITS*DIGIT_W  registered digit values.
- o_wrap  output  1  registered one-cycle pulse on a full-chain wrap.
- o_zero  output  1  all digits zero; decoded combinationally from the o_count register.
- o_done  output  1  registered sticky flag for down-count reaching zero (DOWN_WRAP=0 only).

Behaviour:
- One clock, i_clk. Reset is synchronous and active-low (rst_n). No asynchronous paths.
- Reset (rst_n=0 at an edge): o_count=0, o_wrap=0, o_done=0, hence o_zero=1. Reset overrides all other inputs. Reset asserted mid-count takes effect at the next edge; counting resumes on the first tick after rst_n returns high.
- Priority per edge: rst_n low > i_clear > i_load > count step. Lower-priority requests in the same cycle are discarded, not deferred.
- Clear: o_count=0, o_done=0, o_wrap=0.
- Load: digit k gets min(i_load_val digit k, MAX_k), so out-of-range digits saturate to MAX_k. Also o_done=0, o_wrap=0.
- Count step occurs when i_tick & i_run; latency 1 cycle (new o_count visible after the sampling edge). i_tick with i_run=0 is ignored.
- Up step:
  - Digit 0 increments.
  - A digit at MAX_k with carry-in goes to 0 and propagates carry to digit k+1 in the same cycle, so the whole chain updates atomically on one edge.
  - Carry out of the top digit: o_count becomes all zero and o_wrap=1 for exactly the following cycle.
- Down step:
  - Digit 0 decrements.
  - A digit at 0 with borrow-in goes to MAX_k and propagates borrow.
  - If the chain is all zero before the step:
    - DOWN_WRAP=1: o_count becomes all MAX_k, o_wrap pulses.
    - DOWN_WRAP=0: o_count holds, no o_wrap, o_done stays 1.
  - DOWN_WRAP=0: a step that lands on all-zero sets o_done on that edge.
- o_done clears only on reset, clear or load; an up step does not clear it.
- o_wrap is 0 on every cycle except the one following a wrapping step.
- i_dir may change on any cycle and applies to the next step only; no state is kept across a direction change.
- Digits whose value exceeds MAX_k cannot arise, because load clamps.

Decomposition:
- Shared package (stopwatch_pkg):
  - DIGIT_W default.
  - Direction constants DIR_UP=0, DIR_DOWN=1.
  - Default DIGIT_MAX for MM:SS (16'h5959) and for HH:MM (16'h2359, used with a separate hour-limit check outside this block).
- Sub-module bcd_digit:
  - Parameters W and MAX.
  - Inputs: step enable, dir, carry/borrow in, clear, load, load value.
  - Outputs: value, carry/borrow out.
  - Instantiated N_DIGITS times in a generate loop; the top level holds the wrap/done logic.

Test Plan:
1. rst_n=0 for 2 cycles while i_tick=1, i_run=1 -> o_count=16'h0000, o_wrap=0, o_done=0, o_zero=1.
2. Load 16'h0959, dir=0, one tick -> o_count=16'h1000 next cycle, o_wrap=0. Five more ticks -> 16'h1005.
3. Load 16'h5959, dir=0, one tick -> o_count=16'h0000, o_wrap=1 for exactly one cycle, then 0.
4. Down-count (DOWN_WRAP=0): load 16'h0001, dir=1, tick -> 16'h0000, o_done=1. Two more ticks -> 16'h0000, o_wrap=0, o_done=1. Second instance with DOWN_WRAP=1, from 16'h0000, one tick -> 16'h5959, o_wrap pulses once.
5. i_clear=1, i_load=1, i_tick=1 in the same cycle -> 16'h0000. Then load 16'h7A63 -> 16'h5953 (digits clamped).
6. i_run=0 with 10 ticks -> o_count unchanged. Counting 16'h0123 up, assert rst_n=0 for 1 cycle -> 16'h0000 at the next edge, then the next tick gives 16'h0001.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch/timer datapath: digit width, count
// direction encoding and the standard per-digit maxima for MM:SS and HH:MM.
package stopwatch_pkg;

  localparam int DIGIT_W_DEF = 4;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // HH:MM needs a separate 23:59 hour-limit check outside the counter chain.
  localparam logic [15:0] MAX_MMSS = 16'h5959;
  localparam logic [15:0] MAX_HHMM = 16'h2359;

endpackage : stopwatch_pkg

// File: rtl/bcd_digit.sv
// One digit of the cascaded counter: counts 0..MAX up or down when stepped
// with carry/borrow in, and reports carry/borrow out combinationally.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter int           W   = DIGIT_W_DEF,
  parameter logic [W-1:0] MAX = W'(9)
) (
  input  logic         i_clk,
  input  logic         rst_n,
  input  logic         i_step,
  input  logic         i_dir,
  input  logic         i_cin,
  input  logic         i_clear,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_value,
  output logic         o_cout
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;
  logic         at_limit;

  // The limit that generates carry/borrow depends on direction: MAX going up,
  // zero going down.
  always_comb begin
    at_limit = (i_dir == DIR_DOWN) ? (value_q == '0) : (value_q == MAX);
    o_cout   = i_cin & at_limit;
  end

  always_comb begin
    value_d = value_q;
    if (i_clear) begin
      value_d = '0;
    end else if (i_load) begin
      value_d = (i_load_val > MAX) ? MAX : i_load_val;
    end else if (i_step && i_cin) begin
      if (i_dir == DIR_DOWN) begin
        value_d = at_limit ? MAX : value_q - ONE;
      end else begin
        value_d = at_limit ? '0 : value_q + ONE;
      end
    end
  end

  // NOTE: state registers use non-blocking assignment only; all next-state
  // math lives in always_comb so the flop block stays a plain D/reset mux.
  always_ff @(posedge i_clk) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign o_value = value_q;

endmodule : bcd_digit

// File: rtl/bcd_counter_chain.sv
// Multi-digit cascaded BCD counter on a single clock, advanced by a one-cycle
// tick; owns the chain-level wrap pulse and sticky down-count done flag.
module bcd_counter_chain
  import stopwatch_pkg::*;
#(
  parameter int                          N_DIGITS  = 4,
  parameter int                          DIGIT_W   = DIGIT_W_DEF,
  parameter logic [N_DIGITS*DIGIT_W-1:0] DIGIT_MAX = MAX_MMSS,
  parameter bit                          DOWN_WRAP = 1'b0
) (
  input  logic                          i_clk,
  input  logic                          rst_n,
  input  logic                          i_tick,
  input  logic                          i_run,
  input  logic                          i_dir,
  input  logic                          i_clear,
  input  logic                          i_load,
  input  logic [N_DIGITS*DIGIT_W-1:0]   i_load_val,
  output logic [N_DIGITS*DIGIT_W-1:0]   o_count,
  output logic                          o_wrap,
  output logic                          o_zero,
  output logic                          o_done
);

  localparam int                TW        = N_DIGITS * DIGIT_W;
  localparam logic [TW-1:0]     COUNT_ONE = TW'(1);

  logic [TW-1:0] count;
  logic          chain_cout;
  logic          all_zero;
  logic          is_down;
  logic          step_req;
  logic          hold_at_zero;
  logic          step_en;
  logic          wrap_q, wrap_d;
  logic          done_q, done_d;

  // Each digit gets its own carry signal so the ripple path is a simple
  // chain of distinct nets; the whole chain still settles within one cycle.
  for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
    logic cin;
    logic cout;

    if (k == 0) begin : g_lsd
      assign cin = 1'b1;
    end else begin : g_chain
      assign cin = g_digit[k-1].cout;
    end

    if (k == N_DIGITS - 1) begin : g_msd
      assign chain_cout = cout;
    end

    bcd_digit #(
      .W   (DIGIT_W),
      .MAX (DIGIT_MAX[k*DIGIT_W +: DIGIT_W])
    ) u_digit (
      .i_clk      (i_clk),
      .rst_n      (rst_n),
      .i_step     (step_en),
      .i_dir      (i_dir),
      .i_cin      (cin),
      .i_clear    (i_clear),
      .i_load     (i_load),
      .i_load_val (i_load_val[k*DIGIT_W +: DIGIT_W]),
      .o_value    (count[k*DIGIT_W +: DIGIT_W]),
      .o_cout     (cout)
    );
  end

  always_comb begin
    all_zero     = (count == '0);
    is_down      = (i_dir == DIR_DOWN);
    step_req     = i_tick & i_run & ~i_clear & ~i_load;
    // Saturating mode freezes the chain at zero instead of borrowing through.
    hold_at_zero = is_down & all_zero & ~DOWN_WRAP;
    step_en      = step_req & ~hold_at_zero;

    wrap_d = step_en & chain_cout;

    done_d = done_q;
    if (i_clear || i_load) begin
      done_d = 1'b0;
    end else if (step_req && is_down && !DOWN_WRAP && (all_zero || count == COUNT_ONE)) begin
      done_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!rst_n) begin
      wrap_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
      done_q <= done_d;
    end
  end

  assign o_count = count;
  assign o_wrap  = wrap_q;
  assign o_done  = done_q;
  assign o_zero  = all_zero;

endmodule : bcd_counter_chain

// File: tb/tb_bcd_counter_chain.sv
// Directed bench for bcd_counter_chain: a vector table for single-cycle
// behaviour plus hand sequences for run-hold, mid-count reset and wrap modes.
module tb_bcd_counter_chain;
  import stopwatch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, tick, run, dir, clear, load;
  logic [15:0] load_val;

  logic [15:0] count_s, count_w, count_h;
  logic        wrap_s, zero_s, done_s;
  logic        wrap_w, zero_w, done_w;
  logic        wrap_h, zero_h, done_h;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_counter_chain #(
    .N_DIGITS(4), .DIGIT_W(4), .DIGIT_MAX(MAX_MMSS), .DOWN_WRAP(1'b0)
  ) dut (
    .i_clk(clk), .rst_n(rst_n), .i_tick(tick), .i_run(run), .i_dir(dir),
    .i_clear(clear), .i_load(load), .i_load_val(load_val),
    .o_count(count_s), .o_wrap(wrap_s), .o_zero(zero_s), .o_done(done_s)
  );

  bcd_counter_chain #(
    .N_DIGITS(4), .DIGIT_W(4), .DIGIT_MAX(MAX_MMSS), .DOWN_WRAP(1'b1)
  ) dut_w (
    .i_clk(clk), .rst_n(rst_n), .i_tick(tick), .i_run(run), .i_dir(dir),
    .i_clear(clear), .i_load(load), .i_load_val(load_val),
    .o_count(count_w), .o_wrap(wrap_w), .o_zero(zero_w), .o_done(done_w)
  );

  bcd_counter_chain #(
    .N_DIGITS(4), .DIGIT_W(4), .DIGIT_MAX(MAX_HHMM), .DOWN_WRAP(1'b0)
  ) dut_h (
    .i_clk(clk), .rst_n(rst_n), .i_tick(tick), .i_run(run), .i_dir(dir),
    .i_clear(clear), .i_load(load), .i_load_val(load_val),
    .o_count(count_h), .o_wrap(wrap_h), .o_zero(zero_h), .o_done(done_h)
  );

  typedef struct {
    string       name;
    logic        rst_n, tick, run, dir, clear, load;
    logic [15:0] load_val;
    logic [15:0] exp_count;
    logic        exp_wrap, exp_done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic r, t, ru, d, c, l,
                              input logic [15:0] lv, input logic [15:0] ec,
                              input logic ew, ed);
    vec_t v;
    v.name = name; v.rst_n = r; v.tick = t; v.run = ru; v.dir = d;
    v.clear = c; v.load = l; v.load_val = lv;
    v.exp_count = ec; v.exp_wrap = ew; v.exp_done = ed;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns after the
  // following rising edge.
  task automatic drive(input logic r, t, ru, d, c, l, input logic [15:0] lv);
    @(negedge clk);
    rst_n = r; tick = t; run = ru; dir = d; clear = c; load = l; load_val = lv;
    @(posedge clk);
    #1;
  endtask

  task automatic check_main(input string name, input logic [15:0] ec, input logic ew, ed);
    check({name, ".count"}, 32'(count_s), 32'(ec));
    check({name, ".wrap"},  32'(wrap_s),  32'(ew));
    check({name, ".done"},  32'(done_s),  32'(ed));
    check({name, ".zero"},  32'(zero_s),  32'(ec == 16'h0000));
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; run = 1'b0; dir = DIR_UP;
    clear = 1'b0; load = 1'b0; load_val = 16'h0000;

    //            name            rst tck run dir       clr ld  load_val  exp_count w  d
    vecs.push_back(mk("rst0",      0,  1,  1,  DIR_UP,   0,  0,  16'h0000, 16'h0000, 0, 0));
    vecs.push_back(mk("rst1",      0,  1,  1,  DIR_UP,   0,  0,  16'h0000, 16'h0000, 0, 0));
    vecs.push_back(mk("ld0959",    1,  0,  1,  DIR_UP,   0,  1,  16'h0959, 16'h0959, 0, 0));
    vecs.push_back(mk("up1000",    1,  1,  1,  DIR_UP,   0,  0,  16'h0000, 16'h1000, 0, 0));
    vecs.push_back(mk("up1001",    1,  1,  1,  DIR_UP,   0,  0,  16'h0000, 16'h1001, 0, 0));
    vecs.push_back(mk("up1002",    1,  1,  1,  DIR_UP,   0,  0,  16'h0000, 16'h1002, 0, 0));
    vecs.push_back(mk("up1003",    1,  1,  1,  DIR_UP,   0,  0,  16'h0000, 16'h1003, 0, 0));
    vecs.push_back(mk("up1004",    1,  1,  1,  DIR_UP,   0,  0,  16'h0000, 16'h1004, 0, 0));
    vecs.push_back(mk("up1005",    1,  1,  1,  DIR_UP,   0,  0,  16'h0000, 16'h1005, 0, 0));
    vecs.push_back(mk("ld5959",    1,  0,  1,  DIR_UP,   0,  1,  16'h5959, 16'h5959, 0, 0));
    vecs.push_back(mk("upwrap",    1,  1,  1,  DIR_UP,   0,  0,  16'h0000, 16'h0000, 1, 0));
    vecs.push_back(mk("wrapgone",  1,  0,  1,  DIR_UP,   0,  0,  16'h0000, 16'h0000, 0, 0));
    vecs.push_back(mk("ld1000",    1,  0,  1,  DIR_UP,   0,  1,  16'h1000, 16'h1000, 0, 0));
    vecs.push_back(mk("dnborrow",  1,  1,  1,  DIR_DOWN, 0,  0,  16'h0000, 16'h0959, 0, 0));
    vecs.push_back(mk("ld0001",    1,  0,  1,  DIR_UP,   0,  1,  16'h0001, 16'h0001, 0, 0));
    vecs.push_back(mk("dnzero",    1,  1,  1,  DIR_DOWN, 0,  0,  16'h0000, 16'h0000, 0, 1));
    vecs.push_back(mk("dnsat1",    1,  1,  1,  DIR_DOWN, 0,  0,  16'h0000, 16'h0000, 0, 1));
    vecs.push_back(mk("dnsat2",    1,  1,  1,  DIR_DOWN, 0,  0,  16'h0000, 16'h0000, 0, 1));
    vecs.push_back(mk("upkeepdn",  1,  1,  1,  DIR_UP,   0,  0,  16'h0000, 16'h0001, 0, 1));
    vecs.push_back(mk("clrprio",   1,  1,  1,  DIR_UP,   1,  1,  16'h4321, 16'h0000, 0, 0));
    vecs.push_back(mk("ldclamp",   1,  0,  1,  DIR_UP,   0,  1,  16'h7A63, 16'h5953, 0, 0));
    vecs.push_back(mk("ldprio",    1,  1,  1,  DIR_UP,   0,  1,  16'h0123, 16'h0123, 0, 0));
    vecs.push_back(mk("noruntck",  1,  1,  0,  DIR_UP,   0,  0,  16'h0000, 16'h0123, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].tick, vecs[i].run, vecs[i].dir,
            vecs[i].clear, vecs[i].load, vecs[i].load_val);
      check_main(vecs[i].name, vecs[i].exp_count, vecs[i].exp_wrap, vecs[i].exp_done);
    end

    // Ten ticks with run low: count must not move.
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 0, DIR_UP, 0, 0, 16'h0000);
    end
    check_main("runhold", 16'h0123, 1'b0, 1'b0);

    // Mid-count reset, then counting resumes on the first tick after release.
    drive(1, 1, 1, DIR_UP, 0, 0, 16'h0000);
    check_main("up0124", 16'h0124, 1'b0, 1'b0);
    drive(0, 1, 1, DIR_UP, 0, 0, 16'h0000);
    check_main("midrst", 16'h0000, 1'b0, 1'b0);
    drive(1, 1, 1, DIR_UP, 0, 0, 16'h0000);
    check_main("postrst", 16'h0001, 1'b0, 1'b0);

    // Down step from all-zero: wrapping instance goes to all-max and pulses.
    drive(1, 0, 1, DIR_UP, 1, 0, 16'h0000);
    check("wz.clr.count", 32'(count_w), 32'h0000);
    drive(1, 1, 1, DIR_DOWN, 0, 0, 16'h0000);
    check("wz.count", 32'(count_w), 32'h5959);
    check("wz.wrap",  32'(wrap_w),  32'h1);
    check("wz.done",  32'(done_w),  32'h0);
    check("wz.zero",  32'(zero_w),  32'h0);
    check_main("satdn", 16'h0000, 1'b0, 1'b1);
    drive(1, 0, 1, DIR_DOWN, 0, 0, 16'h0000);
    check("wz.hold", 32'(count_w), 32'h5959);
    check("wz.wrap1cyc", 32'(wrap_w), 32'h0);

    // HH:MM maxima: 23:59 rolls to 00:00 while MM:SS moves to 24:00.
    drive(1, 0, 1, DIR_UP, 0, 1, MAX_HHMM);
    check("hh.ld", 32'(count_h), 32'h2359);
    drive(1, 1, 1, DIR_UP, 0, 0, 16'h0000);
    check("hh.count", 32'(count_h), 32'h0000);
    check("hh.wrap",  32'(wrap_h),  32'h1);
    check_main("ms2400", 16'h2400, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_bcd_counter_chain
